// File: rtl/branch_pkg.sv
// Shared definitions for the branch prediction controller.
//   - bp_state_e   : redirect/flush FSM states
//   - SNT/WNT/WT/ST: 2-bit saturating counter encodings
//   - F3_*         : RV32I branch funct3 codes (for decode stages sharing this package)
//   - sat_update() : next value of a 2-bit saturating counter
package branch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } bp_state_e;

  localparam logic [1:0] SNT = 2'b00;  // strong not-taken
  localparam logic [1:0] WNT = 2'b01;  // weak not-taken
  localparam logic [1:0] WT  = 2'b10;  // weak taken
  localparam logic [1:0] ST  = 2'b11;  // strong taken

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == ST)  ? ST  : cnt + 2'd1;
    else       return (cnt == SNT) ? SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: ENTRIES 2-bit saturating counters.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (all entries -> WNT)
//   rd_idx_i      : combinational read index
//   rd_cnt_o      : counter at rd_idx_i (value before any same-cycle update)
//   upd_en_i      : apply one saturating step at upd_idx_i on the next edge
//   upd_idx_i     : update index
//   upd_taken_i   : 1 = step toward taken, 0 = step toward not-taken
module branch_bht
  import branch_pkg::*;
#(
  parameter int ENTRIES = 16,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_cnt_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  logic [1:0] cnt_q [ENTRIES];

  // NOTE: this is a small flop array, not a RAM macro, so every entry is
  // reset; predictions straight out of reset must start at weak not-taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= WNT;
    end else if (upd_en_i) begin
      cnt_q[upd_idx_i] <= sat_update(cnt_q[upd_idx_i], upd_taken_i);
    end
  end

  // Reading the flops directly gives the pre-update value on a same-index hit.
  assign rd_cnt_o = cnt_q[rd_idx_i];

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch predictor and mispredict recovery controller.
// Predicts from a BHT of 2-bit counters, trains it on resolved branches and,
// on a mispredict, pulses redirect_valid for one cycle and holds flush for
// FLUSH_CYCLES cycles in total. Resolves seen while recovering are wrong-path
// and ignored.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   if_valid, if_pc          : fetch lookup;  pred_taken : combinational prediction
//   ex_valid, ex_pc, ex_pred_taken, ex_taken, ex_target : resolved branch from EX
//   redirect_valid, redirect_pc : fetch redirect (pc holds between pulses)
//   flush                    : kill wrong-path instructions
//   stat_branches, stat_mispredicts : statistics
// Build option: define BRANCH_PREDICT_STATS_EN to implement the statistics
// counters; otherwise the stat ports are tied to zero.
module branch_predict_ctrl
  import branch_pkg::*;
#(
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_pred_taken,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int         IDX_W      = $clog2(BHT_ENTRIES);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  bp_state_e   state_q, state_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic [31:0] redirect_pc_q;
  logic [1:0]  rd_cnt;
  logic        accept, mispredict;
  logic        unused_pc_bits;

  assign accept     = ex_valid && (state_q == IDLE);
  assign mispredict = accept && (ex_taken != ex_pred_taken);

  // Only the index bits of if_pc select a counter.
  assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

  branch_bht #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clk         (clk),
    .rst         (rst),
    .rd_idx_i    (if_pc[IDX_W+1:2]),
    .rd_cnt_o    (rd_cnt),
    .upd_en_i    (accept),
    .upd_idx_i   (ex_pc[IDX_W+1:2]),
    .upd_taken_i (ex_taken)
  );

  assign pred_taken = if_valid & rd_cnt[1];

  // NOTE: defaults first so every path assigns every output -- no latches.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: if (mispredict) state_d = REDIRECT;
      REDIRECT: begin
        if (FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          fcnt_d  = FLUSH_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        // Counter holds the number of FLUSH cycles still to spend, this one included.
        if (fcnt_q <= 3'd1) begin
          state_d = IDLE;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops
  // update together from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      fcnt_q        <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (mispredict) redirect_pc_q <= ex_taken ? ex_target : ex_pc + 32'd4;
    end
  end

  // Decoded straight from the state register, so reset clears them at once.
  assign redirect_valid = (state_q == REDIRECT);
  assign flush          = (state_q != IDLE);
  assign redirect_pc    = redirect_pc_q;

`ifdef BRANCH_PREDICT_STATS_EN
  logic [31:0] br_q, mis_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_q  <= '0;
      mis_q <= '0;
    end else begin
      if (accept)     br_q  <= br_q + 32'd1;
      if (mispredict) mis_q <= mis_q + 32'd1;
    end
  end

  assign stat_branches    = br_q;
  assign stat_mispredicts = mis_q;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: directed vector table,
// reset-during-flush sequence, then randomized traffic against a model.
module tb_branch_predict_ctrl;

  localparam int N  = 16;
  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  branch_predict_ctrl #(.BHT_ENTRIES(N), .FLUSH_CYCLES(FC)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_pred_taken    (ex_pred_taken),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .flush            (flush),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Statistics exist only when the build option is on.
  function automatic logic [31:0] stat_exp(input int v);
`ifdef BRANCH_PREDICT_STATS_EN
    return 32'(v);
`else
    return 32'd0 + 32'(v & 0);
`endif
  endfunction

  task automatic drive(input logic ifv, input logic [31:0] ifp, input logic exv,
                       input logic [31:0] exp_c, input logic exp_p, input logic ext,
                       input logic [31:0] extg);
    if_valid = ifv; if_pc = ifp; ex_valid = exv; ex_pc = exp_c;
    ex_pred_taken = exp_p; ex_taken = ext; ex_target = extg;
  endtask

  // ---------------- behavioural reference model ----------------
  int          m_bht [N];
  int          m_busy;   // cycles of flush still owed
  bit          m_rv;
  logic [31:0] m_rpc;
  int          m_br, m_mis;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_bht[i] = 1;
    m_busy = 0; m_rv = 0; m_rpc = 0; m_br = 0; m_mis = 0;
  endtask

  task automatic model_edge();
    int i;
    m_rv = 0;
    if (m_busy > 0) begin
      m_busy--;
    end else if (ex_valid) begin
      i = idx_of(ex_pc);
      if (ex_taken) m_bht[i] = (m_bht[i] == 3) ? 3 : m_bht[i] + 1;
      else          m_bht[i] = (m_bht[i] == 0) ? 0 : m_bht[i] - 1;
      m_br++;
      if (ex_taken != ex_pred_taken) begin
        m_mis++;
        m_rpc  = ex_taken ? ex_target : ex_pc + 32'd4;
        m_busy = FC;
        m_rv   = 1;
      end
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        ifv;
    logic [31:0] ifpc;
    logic        exv;
    logic [31:0] expc;
    logic        exp_in;
    logic        ext;
    logic [31:0] extgt;
    logic        e_pred;
    logic        e_rv;
    logic        e_fl;
    logic [31:0] e_rpc;
    int          e_br;
    int          e_mis;
  } vec_t;

  vec_t tbl [15];

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    //           ifv ifpc          exv expc          p  t  target        pred rv fl rpc          br mis
    tbl[0]  = '{1, 32'h100,      0, 32'h0,        0, 0, 32'h0,      0,   0, 0, 32'h0,  0, 0};
    tbl[1]  = '{1, 32'h100,      1, 32'h100,      1, 1, 32'h0,      0,   0, 0, 32'h0,  1, 0};
    tbl[2]  = '{1, 32'h100,      1, 32'h100,      1, 1, 32'h0,      1,   0, 0, 32'h0,  2, 0};
    tbl[3]  = '{1, 32'h100,      0, 32'h0,        0, 0, 32'h0,      1,   0, 0, 32'h0,  2, 0};
    tbl[4]  = '{1, 32'h100,      1, 32'h200,      0, 1, 32'h80,     1,   1, 1, 32'h80, 3, 1};
    tbl[5]  = '{0, 32'h100,      0, 32'h0,        0, 0, 32'h0,      0,   0, 1, 32'h80, 3, 1};
    tbl[6]  = '{1, 32'h200,      0, 32'h0,        0, 0, 32'h0,      1,   0, 0, 32'h80, 3, 1};
    tbl[7]  = '{1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 1, 0, 32'h1234,   0,   1, 1, 32'h0,  4, 2};
    tbl[8]  = '{1, 32'h4,        1, 32'h4,        0, 1, 32'h40,     0,   0, 1, 32'h0,  4, 2};
    tbl[9]  = '{1, 32'h4,        1, 32'h4,        0, 1, 32'h40,     0,   0, 0, 32'h0,  4, 2};
    tbl[10] = '{1, 32'h4,        0, 32'h0,        0, 0, 32'h0,      0,   0, 0, 32'h0,  4, 2};
    tbl[11] = '{1, 32'hFFFFFFFC, 0, 32'h0,        0, 0, 32'h0,      0,   0, 0, 32'h0,  4, 2};
    tbl[12] = '{1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 1, 1, 32'h0,      0,   0, 0, 32'h0,  5, 2};
    tbl[13] = '{1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 1, 1, 32'h0,      0,   0, 0, 32'h0,  6, 2};
    tbl[14] = '{1, 32'hFFFFFFFC, 0, 32'h0,        0, 0, 32'h0,      1,   0, 0, 32'h0,  6, 2};

    // Reset state.
    rst = 1'b1;
    drive(1, 32'h100, 0, 0, 0, 0, 0);
    #2;
    check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_pred_0x100", 32'(pred_taken), 32'd0);
    check("rst_stat_br", stat_branches, stat_exp(0));
    check("rst_stat_mis", stat_mispredicts, stat_exp(0));

    // Directed table: pred_taken before the edge, registered outputs after it.
    for (int r = 0; r < 15; r++) begin
      drive(tbl[r].ifv, tbl[r].ifpc, tbl[r].exv, tbl[r].expc, tbl[r].exp_in,
            tbl[r].ext, tbl[r].extgt);
      #1;
      check($sformatf("row%0d_pred", r), 32'(pred_taken), 32'(tbl[r].e_pred));
      @(posedge clk); #1;
      check($sformatf("row%0d_rv", r), 32'(redirect_valid), 32'(tbl[r].e_rv));
      check($sformatf("row%0d_flush", r), 32'(flush), 32'(tbl[r].e_fl));
      check($sformatf("row%0d_rpc", r), redirect_pc, tbl[r].e_rpc);
      check($sformatf("row%0d_br", r), stat_branches, stat_exp(tbl[r].e_br));
      check($sformatf("row%0d_mis", r), stat_mispredicts, stat_exp(tbl[r].e_mis));
    end

    // Reset asserted while in FLUSH.
    drive(0, 0, 1, 32'h8, 1, 0, 32'h500);
    @(posedge clk); #1;                       // now REDIRECT
    check("seq_redirect_pc", redirect_pc, 32'hC);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;                       // now FLUSH
    check("seq_in_flush", 32'(flush), 32'd1);
    rst = 1'b1;
    #1;
    check("seq_async_flush", 32'(flush), 32'd0);
    check("seq_async_rv", 32'(redirect_valid), 32'd0);
    check("seq_async_rpc", redirect_pc, 32'd0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      drive(1, 32'(i) << 2, 0, 0, 0, 0, 0);
      #1;
      check($sformatf("post_rst_entry%0d", i), 32'(pred_taken), 32'd0);
    end
    // Entry 0 was strong-taken before reset; one taken step must now predict taken.
    drive(1, 32'h0, 1, 32'h0, 1, 1, 32'h0);
    @(posedge clk); #1;
    check("post_rst_entry0_step", 32'(pred_taken), 32'd1);
    check("post_rst_stat_br", stat_branches, stat_exp(1));

    // Randomized traffic against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      logic [31:0] ep, ip;
      logic        ifv, exv, pt, tk;
      ep  = (32'($urandom_range(0, 3)) << 28) | (32'($urandom_range(0, 31)) << 2);
      if ($urandom_range(0, 15) == 0) ep = 32'hFFFFFFFC;
      ip  = ($urandom_range(0, 3) == 0) ? ep
          : (32'($urandom_range(0, 3)) << 28) | (32'($urandom_range(0, 31)) << 2);
      ifv = 1'($urandom_range(0, 1));
      exv = ($urandom_range(0, 3) != 0);
      tk  = 1'($urandom_range(0, 1));
      pt  = ($urandom_range(0, 3) == 0) ? ~tk : tk;
      drive(ifv, ip, exv, ep, pt, tk, $urandom);
      #1;
      check($sformatf("rnd%0d_pred", c), 32'(pred_taken),
            32'(ifv && (m_bht[idx_of(ip)] >= 2)));
      @(posedge clk);
      model_edge();
      #1;
      check($sformatf("rnd%0d_rv", c), 32'(redirect_valid), 32'(m_rv));
      check($sformatf("rnd%0d_flush", c), 32'(flush), 32'(m_busy > 0));
      check($sformatf("rnd%0d_rpc", c), redirect_pc, m_rpc);
      check($sformatf("rnd%0d_br", c), stat_branches, stat_exp(m_br));
      check($sformatf("rnd%0d_mis", c), stat_mispredicts, stat_exp(m_mis));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
